// File: rtl/educell_esm_pkg.sv
// Shared definitions for the EDU cell ESM index sequencer: state encoding,
// a constant clog2 helper and the default snapshot width (aqmeas threshold).
`ifndef EDUCELL_AQMEAS_THRESHOLD
`define EDUCELL_AQMEAS_THRESHOLD 8
`endif

package educell_esm_pkg;

  localparam int ESM_W_DEF = `EDUCELL_AQMEAS_THRESHOLD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } esm_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/educell_esm_prienc.sv
// Combinational priority encoder over an ESM snapshot: lowest set bit by
// default, highest set bit when ESMIDX_MSB_FIRST_EN is defined.
module educell_esm_prienc #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             onehot_o
);

  always_comb begin
    idx_o = '0;
`ifdef ESMIDX_MSB_FIRST_EN
    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
`else
    // Descending scan: the last hit, i.e. the lowest set bit, wins.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
`endif
  end

  assign any_o    = |vec_i;
  assign onehot_o = any_o && ((vec_i & (vec_i - W'(1))) == '0);

endmodule

// File: rtl/educell_esmunit_idx_seq.sv
// Sequential ESM set-bit index streamer: accepts one snapshot, emits up to
// MAX_IDX set-bit indices, then pulses done with popcount/overflow.
// Optional ESMIDX_MSB_FIRST_EN streams indices highest-first.
module educell_esmunit_idx_seq
  import educell_esm_pkg::*;
#(
  parameter  int ESM_W   = ESM_W_DEF,
  parameter  int MAX_IDX = 2,
  localparam int IDX_W   = (clog2(ESM_W) < 1) ? 1 : clog2(ESM_W),
  localparam int CNT_W   = clog2(ESM_W + 1),
  localparam int ORD_W   = clog2(MAX_IDX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  // Both ports: a transfer happens in a cycle where valid and ready are both
  // high; the producer holds its payload stable while valid is high and ready low.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ESM_W-1:0] in_esm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [ORD_W-1:0] out_ord,
  output logic             out_last,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  esm_state_e       state_q, state_d;
  logic [ESM_W-1:0] work_q, work_d;
  logic [ORD_W-1:0] emit_q, emit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pop;
  logic [IDX_W-1:0] pe_idx;
  logic             pe_any;
  logic             pe_onehot;
  logic             last;

  educell_esm_prienc #(
    .W     (ESM_W),
    .IDX_W (IDX_W)
  ) u_prienc (
    .vec_i    (work_q),
    .idx_o    (pe_idx),
    .any_o    (pe_any),
    .onehot_o (pe_onehot)
  );

  always_comb begin
    pop = '0;
    for (int i = 0; i < ESM_W; i++) begin
      pop = pop + CNT_W'(in_esm[i]);
    end
  end

  // Stream ends on the MAX_IDX-th index or when only one bit remains.
  assign last = (emit_q == ORD_W'(MAX_IDX - 1)) || pe_onehot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      emit_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      emit_q  <= emit_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    emit_d    = emit_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_ord   = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    cnt       = '0;
    overflow  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_esm;
          cnt_d   = pop;
          emit_d  = '0;
          state_d = (in_esm != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        out_valid = pe_any;
        out_idx   = pe_idx;
        out_ord   = emit_q;
        out_last  = last;
        if (out_ready && pe_any) begin
          work_d = work_q & ~(ESM_W'(1) << pe_idx);
          emit_d = emit_q + ORD_W'(1);
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        cnt      = cnt_q;
        overflow = (cnt_q > CNT_W'(MAX_IDX));
        work_d   = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_educell_esmunit_idx_seq.sv
// Directed bench for educell_esmunit_idx_seq (ESM_W=8, MAX_IDX=2).
module tb_educell_esmunit_idx_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_esm;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [1:0] out_ord;
  logic       out_last;
  logic       done;
  logic [3:0] cnt;
  logic       overflow;
  logic       busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

`ifdef ESMIDX_MSB_FIRST_EN
  localparam logic [2:0] T1_A = 3'd5, T1_B = 3'd2, T2_A = 3'd7, T2_B = 3'd5;
`else
  localparam logic [2:0] T1_A = 3'd2, T1_B = 3'd5, T2_A = 3'd0, T2_B = 3'd4;
`endif

  educell_esmunit_idx_seq #(.ESM_W(8), .MAX_IDX(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_esm    (in_esm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_ord   (out_ord),
    .out_last  (out_last),
    .done      (done),
    .cnt       (cnt),
    .overflow  (overflow),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a snapshot for one cycle; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] esm);
    in_valid = 1'b1;
    in_esm   = esm;
    chk("send_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_esm   = 8'($urandom_range(0, 255));
  endtask

  // One accepted index beat (out_ready must already be high).
  task automatic beat(input string tag, input logic [1:0] ord, input logic last);
    logic [2:0] e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_idx"}, out_idx, e);
    chk({tag, "_ord"}, out_ord, ord);
    chk({tag, "_last"}, out_last, last);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    @(negedge clk);
  endtask

  task automatic fin(input string tag, input logic [3:0] c, input logic ovf);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_cnt"}, cnt, c);
    chk({tag, "_ovf"}, overflow, ovf);
    chk({tag, "_valid_low"}, out_valid, 0);
    chk({tag, "_in_ready_low"}, in_ready, 0);
    chk({tag, "_state"}, dbg_state, 2);
    @(negedge clk);
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
    chk({tag, "_cnt_off"}, cnt, 0);
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_esm    = 8'h00;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two set bits: both emitted, no overflow.
    exp_q.push_back(T1_A);
    exp_q.push_back(T1_B);
    send(8'b0010_0100);
    beat("t1_b0", 2'd0, 1'b0);
    beat("t1_b1", 2'd1, 1'b1);
    fin("t1", 4'd2, 1'b0);

    // Four set bits: two emitted, rest discarded; in_valid ignored while busy.
    exp_q.push_back(T2_A);
    exp_q.push_back(T2_B);
    send(8'b1011_0001);
    in_valid = 1'b1;
    in_esm   = 8'hFF;
    beat("t2_b0", 2'd0, 1'b0);
    beat("t2_b1", 2'd1, 1'b1);
    in_valid = 1'b0;
    fin("t2", 4'd4, 1'b1);

    // Empty snapshot: straight to done, no index beat.
    send(8'h00);
    fin("t3", 4'd0, 1'b0);
    chk("t3_no_valid", out_valid, 0);

    // Single bit under backpressure for three cycles.
    out_ready = 1'b0;
    send(8'b1000_0000);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_idx", out_idx, 7);
      chk("t4_hold_ord", out_ord, 0);
      chk("t4_hold_last", out_last, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    exp_q.push_back(3'd7);
    beat("t4_b0", 2'd0, 1'b1);
    fin("t4", 4'd1, 1'b0);

    // Reset during the first out_valid cycle drops the stream at once.
    send(8'b0000_0110);
    chk("t5_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rel_done", done, 0);
    exp_q.push_back(3'd3);
    send(8'b0000_1000);
    beat("t5_b0", 2'd0, 1'b1);
    fin("t5", 4'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
